// File: rtl/move_pkg.sv
// Shared types and helpers for the move-control input stage.
package move_pkg;

  // Direction requested by the synchronised keys (or held by the FSM).
  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  // Hold-to-repeat controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } state_t;

  // Left alone or right alone selects a direction; both keys cancel out.
  function automatic dir_t decode_dir(input logic key_l, input logic key_r);
    dir_t d;
    d = DIR_NONE;
    if (key_l && !key_r) begin
      d = DIR_LEFT;
    end else if (key_r && !key_l) begin
      d = DIR_RIGHT;
    end
    return d;
  endfunction

  // Larger of two integers, used to size the repeat counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for asynchronous push-button levels.
module key_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives a settled level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/move_ctrl.sv
// Move controller: synchronises the keys, generates the move tick and
// produces registered update_player/left/right strobes with hold-to-repeat.
module move_ctrl
  import move_pkg::*;
#(
  parameter int TICK_DIV     = 4,
  parameter int REPEAT_DELAY = 3,
  parameter int REPEAT_RATE  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_left,
  input  logic key_right,
  input  logic game_Over,
  output logic update_player,
  output logic left,
  output logic right
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W  = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]  RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [1:0]        keys_sync;
  dir_t              dir;

  logic [TICK_W-1:0] tick_cnt_q;
  logic [TICK_W-1:0] tick_cnt_d;
  logic              tick;

  state_t            state_q;
  state_t            state_d;
  dir_t              held_dir_q;
  dir_t              held_dir_d;
  logic [CNT_W-1:0]  rpt_cnt_q;
  logic [CNT_W-1:0]  rpt_cnt_d;
  logic [CNT_W-1:0]  rpt_limit;
  logic              emit;

  logic              upd_q;
  logic              upd_d;
  logic              left_q;
  logic              left_d;
  logic              right_q;
  logic              right_d;

  key_sync #(
    .WIDTH (2)
  ) u_key_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i ({key_left, key_right}),
    .sync_o  (keys_sync)
  );

  assign dir = decode_dir(keys_sync[1], keys_sync[0]);

  // Free-running tick divider; keeps counting through game over.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // FSM state, held direction, repeat counter and registered strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      held_dir_q <= DIR_NONE;
      rpt_cnt_q  <= '0;
      upd_q      <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_dir_q <= held_dir_d;
      rpt_cnt_q  <= rpt_cnt_d;
      upd_q      <= upd_d;
      left_q     <= left_d;
      right_q    <= right_d;
    end
  end

  // Next-state logic; a release or direction change beats an emit.
  always_comb begin
    state_d    = state_q;
    held_dir_d = held_dir_q;
    rpt_cnt_d  = rpt_cnt_q;
    emit       = 1'b0;
    rpt_limit  = (state_q == DELAY) ? DELAY_LAST : RATE_LAST;

    if (game_Over) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dir != DIR_NONE) begin
            held_dir_d = dir;
            state_d    = ARMED;
          end
        end
        ARMED: begin
          // A release here is ignored so a short tap still moves once.
          if (dir != DIR_NONE) begin
            held_dir_d = dir;
          end
          if (tick) begin
            emit      = 1'b1;
            rpt_cnt_d = '0;
            state_d   = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (dir == DIR_NONE) begin
            state_d = IDLE;
          end else if (dir != held_dir_q) begin
            held_dir_d = dir;
            state_d    = ARMED;
          end else if (tick) begin
            if (rpt_cnt_q == rpt_limit) begin
              emit      = 1'b1;
              rpt_cnt_d = '0;
              state_d   = REPEAT;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output decode: strobe plus exactly one direction qualifier on emit.
  always_comb begin
    upd_d   = emit;
    left_d  = emit && (held_dir_d == DIR_LEFT);
    right_d = emit && (held_dir_d == DIR_RIGHT);
  end

  assign update_player = upd_q;
  assign left          = left_q;
  assign right         = right_q;

endmodule

// File: tb/tb_move_ctrl.sv
// Bench for move_ctrl: directed key sequences, a behavioural model checked
// every cycle, and hand-computed move-cycle tables that pin the model.
module tb_move_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int REPEAT_DELAY = 3;
  localparam int REPEAT_RATE  = 2;

  logic clk;
  logic reset_n;
  logic kl;
  logic kr;
  logic go;
  logic upd;
  logic lft;
  logic rgt;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  // Model state: 0 none, 1 left, 2 right for directions and expected code.
  int m_exp = 0;
  int m_cyc = 0;
  bit m_s1l = 0, m_s1r = 0, m_s2l = 0, m_s2r = 0;
  bit m_active = 0;
  bit m_pending = 0;
  int m_hdir = 0;
  int m_moves = 0;
  int m_ticks = 0;
  int m_d;
  bit m_tk;
  int m_e;

  move_ctrl #(
    .TICK_DIV     (TICK_DIV),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .clk           (clk),
    .reset         (reset_n),
    .key_left      (kl),
    .key_right     (kr),
    .game_Over     (go),
    .update_player (upd),
    .left          (lft),
    .right         (rgt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: tracks a hold as "waiting for first move" or
  // "counting ticks since the last move" (first gap REPEAT_DELAY, then RATE).
  initial begin
    forever begin
      @(posedge clk);
      m_e = 0;
      if (!reset_n) begin
        m_s1l = 0; m_s1r = 0; m_s2l = 0; m_s2r = 0;
        m_cyc = 0; m_active = 0; m_pending = 0; m_hdir = 0;
        m_moves = 0; m_ticks = 0;
      end else begin
        m_d  = (m_s2l && !m_s2r) ? 1 : ((m_s2r && !m_s2l) ? 2 : 0);
        m_tk = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
        if (go) begin
          m_active = 0;
        end else if (!m_active) begin
          if (m_d != 0) begin
            m_active = 1; m_pending = 1; m_hdir = m_d;
          end
        end else if (m_pending) begin
          if (m_d != 0) m_hdir = m_d;
          if (m_tk) begin
            m_e = m_hdir; m_pending = 0; m_moves = 1; m_ticks = 0;
          end
        end else if (m_d == 0) begin
          m_active = 0;
        end else if (m_d != m_hdir) begin
          m_hdir = m_d; m_pending = 1;
        end else if (m_tk) begin
          m_ticks = m_ticks + 1;
          if (m_ticks == ((m_moves == 1) ? REPEAT_DELAY : REPEAT_RATE)) begin
            m_e = m_hdir; m_moves = 2; m_ticks = 0;
          end
        end
        m_cyc = m_cyc + 1;
        m_s2l = m_s1l; m_s2r = m_s1r;
        m_s1l = kl;    m_s1r = kr;
      end
      m_exp = m_e;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        checks++;
        if (upd !== (m_exp != 0) || lft !== (m_exp == 1) || rgt !== (m_exp == 2)) begin
          errors++;
          $display("FAIL model t=%0t upd/l/r=%b%b%b want %b%b%b", $time, upd, lft, rgt,
                   (m_exp != 0), (m_exp == 1), (m_exp == 2));
        end
        checks++;
        if (lft === 1'b1 && rgt === 1'b1) begin
          errors++;
          $display("FAIL both_dirs t=%0t left=%b right=%b want not both", $time, lft, rgt);
        end
      end
    end
  end

  // Hand-computed move cycles: 0 none, 1 left, 2 right.
  function automatic int exp_lit(input int t, input int n);
    case (t)
      1, 7: return (n inside {4, 16, 24, 32, 40}) ? 1 : 0;
      2:    return (n == 4) ? 2 : 0;
      3:    return (n inside {24, 36}) ? 1 : 0;
      4: begin
        if (n == 4) return 1;
        if (n inside {16, 28, 36}) return 2;
        return 0;
      end
      5:    return (n inside {16, 28, 36}) ? 1 : 0;
      6:    return (n == 4) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic set_inputs(input int t, input int n);
    kl = 1'b0; kr = 1'b0; go = 1'b0;
    case (t)
      1, 6, 7: kl = 1'b1;
      2: kr = (n == 0);
      3: begin kl = 1'b1; kr = (n < 20); end
      4: begin kl = (n < 10); kr = (n >= 10); end
      5: begin kl = 1'b1; go = (n < 14); end
      default: ;
    endcase
  endtask

  task automatic check_lit(input int t, input int n);
    int c;
    c = exp_lit(t, n);
    checks++;
    if (upd !== (c != 0) || lft !== (c == 1) || rgt !== (c == 2)) begin
      errors++;
      $display("FAIL lit_t%0d_c%0d upd/l/r=%b%b%b want %b%b%b", t, n, upd, lft, rgt,
               (c != 0), (c == 1), (c == 2));
    end
    checks++;
    if (m_exp != c) begin
      errors++;
      $display("FAIL model_pin_t%0d_c%0d model=%0d want %0d", t, n, m_exp, c);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 0 after reset.
  task automatic start_cold();
    reset_n = 1'b0; kl = 1'b0; kr = 1'b0; go = 1'b0;
    @(negedge clk);
    checks++;
    if (upd !== 1'b0 || lft !== 1'b0 || rgt !== 1'b0) begin
      errors++;
      $display("FAIL reset_state upd/l/r=%b%b%b want 000", upd, lft, rgt);
    end
    reset_n = 1'b1;
  endtask

  task automatic run_phase(input int t, input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      set_inputs(t, n);
      check_lit(t, n);
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; kl = 1'b0; kr = 1'b0; go = 1'b0;
    repeat (2) @(negedge clk);
    model_on = 1'b1;

    start_cold(); run_phase(1, 44);
    start_cold(); run_phase(2, 44);
    start_cold(); run_phase(3, 40);
    start_cold(); run_phase(4, 40);
    start_cold(); run_phase(5, 40);

    // Reset in the middle of a hold, on the tick that would repeat.
    start_cold();
    run_phase(6, 15);
    set_inputs(6, 15);
    check_lit(6, 15);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (upd !== 1'b0 || lft !== 1'b0 || rgt !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset upd/l/r=%b%b%b want 000", upd, lft, rgt);
    end
    reset_n = 1'b1;
    run_phase(7, 44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
